// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and
// the byte-enable merge used when committing a write.
package axi_lite_pkg;

   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   localparam logic [2:0] RESP_OKAY   = 3'd0;
   localparam logic [2:0] RESP_SLVERR = 3'd2;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

   // Replace only the bytes whose strobe bit is set.
   function automatic logic [AXI_DATA_W-1:0] strb_merge(
      input logic [AXI_DATA_W-1:0] old_val,
      input logic [AXI_DATA_W-1:0] data_val,
      input logic [AXI_STRB_W-1:0] strb
   );
      logic [AXI_DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < AXI_STRB_W; i++) begin
         if (strb[i]) res[8*i +: 8] = data_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank responder.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commits when both are present
// W_RESP | write committed, holding bvalid/bresp until bready
// R_IDLE | arready high, waiting for an AR handshake
// R_DATA | holding rvalid/rdata/rresp until rready
//
// Write and read channels run independently. A write commits on the same
// edge as the later of its AW/W handshakes, so a read accepted on that edge
// still sees the old register contents.
import axi_lite_pkg::*;

module axi_lite_reg_slave #(
   parameter int DATA_WIDTH = AXI_DATA_W,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int NUM_REGS   = 8
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [RESP_WIDTH-1:0]   s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [RESP_WIDTH-1:0]   s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   w_state_e              wstate_q, wstate_d;
   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [RESP_WIDTH-1:0] bresp_q;
   logic                  aw_fire, w_fire, commit;

   r_state_e              rstate_q, rstate_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [RESP_WIDTH-1:0] rresp_q;
   logic                  ar_fire;

   // A channel handshaking on the commit edge is used directly, not its latch.
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  wr_in_range, rd_in_range;
   logic [4:0]            unused_bits;

   assign wr_addr     = aw_held_q ? awaddr_q : s_axi_awaddr;
   assign wr_data     = w_held_q  ? wdata_q  : s_axi_wdata;
   assign wr_strb     = w_held_q  ? wstrb_q  : s_axi_wstrb[STRB_W-1:0];
   assign wr_idx      = wr_addr[ADDR_WIDTH-1:2];
   assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
   assign wr_in_range = wr_idx < NUM_REGS_IDX;
   assign rd_in_range = rd_idx < NUM_REGS_IDX;
   assign unused_bits = {wr_addr[1:0], s_axi_araddr[1:0], s_axi_wstrb[STRB_W]};

   assign s_axi_bresp = bresp_q;
   assign s_axi_rdata = rdata_q;
   assign s_axi_rresp = rresp_q;

   // Write FSM next state, channel readies and commit strobe.
   always_comb begin
      wstate_d      = wstate_q;
      aw_held_d     = aw_held_q;
      w_held_d      = w_held_q;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      aw_fire       = 1'b0;
      w_fire        = 1'b0;
      commit        = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            s_axi_awready = !s_axi_areset && !aw_held_q;
            s_axi_wready  = !s_axi_areset && !w_held_q;
            aw_fire       = s_axi_awvalid && s_axi_awready;
            w_fire        = s_axi_wvalid && s_axi_wready;
            if (aw_fire) aw_held_d = 1'b1;
            if (w_fire)  w_held_d  = 1'b1;
            if (aw_held_d && w_held_d) begin
               commit   = 1'b1;
               wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Write FSM state, AW/W latches and write response.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= '0;
      end else begin
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         if (aw_fire) awaddr_q <= s_axi_awaddr;
         if (w_fire) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb[STRB_W-1:0];
         end
         if (commit) bresp_q <= wr_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end
   end

   // Register bank; only an in-range commit touches it.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit && wr_in_range) begin
         regs_q[wr_idx[SEL_W-1:0]] <= strb_merge(regs_q[wr_idx[SEL_W-1:0]], wr_data, wr_strb);
      end
   end

   // Read FSM next state and handshake signals.
   always_comb begin
      rstate_d      = rstate_q;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      ar_fire       = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            s_axi_arready = !s_axi_areset;
            ar_fire       = s_axi_arvalid && s_axi_arready;
            if (ar_fire) rstate_d = R_DATA;
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read FSM state and captured read data/response.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         rstate_q <= R_IDLE;
         rdata_q  <= '0;
         rresp_q  <= '0;
      end else begin
         rstate_q <= rstate_d;
         if (ar_fire) begin
            rdata_q <= rd_in_range ? regs_q[rd_idx[SEL_W-1:0]] : '0;
            rresp_q <= rd_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized and directed bench for axi_lite_reg_slave against a plain
// array model of the register map.
module tb_axi_lite_reg_slave;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic [7:0]  awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [4:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [2:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [7:0]  araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [2:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_regs [8];

   always #5 clk = ~clk;

   axi_lite_reg_slave dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (areset),
      .s_axi_awaddr (awaddr),
      .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_wdata  (wdata),
      .s_axi_wstrb  (wstrb),
      .s_axi_wvalid (wvalid),
      .s_axi_wready (wready),
      .s_axi_bresp  (bresp),
      .s_axi_bvalid (bvalid),
      .s_axi_bready (bready),
      .s_axi_araddr (araddr),
      .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_rdata  (rdata),
      .s_axi_rresp  (rresp),
      .s_axi_rvalid (rvalid),
      .s_axi_rready (rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: word index = byte address / 4, eight registers.
   function automatic logic [2:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                              input logic [4:0] strb);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= 8) return 3'd2;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            model_regs[idx] = (model_regs[idx] & ~(32'hFF << (8 * b))) |
                              (data & (32'hFF << (8 * b)));
         end
      end
      return 3'd0;
   endfunction

   task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= 8) begin
         data = 32'd0;
         resp = 3'd2;
      end else begin
         data = model_regs[idx];
         resp = 3'd0;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [2:0] resp);
      int   cyc;
      bit   aw_done, w_done;
      logic [2:0] resp0;
      aw_done = 0;
      w_done  = 0;
      cyc     = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge clk);
         chk("b_early", {31'd0, bvalid}, 32'd0);
         awaddr  = addr;
         wdata   = data;
         wstrb   = strb;
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready)   w_done  = 1;
         cyc++;
         @(posedge clk);
      end
      chk("w_hs_bound", {31'd0, aw_done && w_done}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk("b_latency", {31'd0, bvalid}, 32'd1);
      resp0 = bresp;
      for (int k = 0; k < b_dly; k++) begin
         chk("b_hold", {31'd0, bvalid}, 32'd1);
         chk("b_stable", {29'd0, bresp}, {29'd0, resp0});
         chk("aw_rdy_low", {31'd0, awready}, 32'd0);
         chk("w_rdy_low", {31'd0, wready}, 32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      resp   = bresp;
      @(negedge clk);
      bready = 1'b0;
      chk("b_drop", {31'd0, bvalid}, 32'd0);
      chk("aw_rdy_back", {31'd0, awready}, 32'd1);
      chk("w_rdy_back", {31'd0, wready}, 32'd1);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [2:0] resp);
      int   cyc;
      bit   done;
      logic [31:0] d0;
      logic [2:0]  r0;
      done = 0;
      cyc  = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         chk("r_early", {31'd0, rvalid}, 32'd0);
         araddr  = addr;
         arvalid = (cyc >= ar_dly);
         if (arvalid && arready) done = 1;
         cyc++;
         @(posedge clk);
      end
      chk("ar_hs_bound", {31'd0, done}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("r_latency", {31'd0, rvalid}, 32'd1);
      d0 = rdata;
      r0 = rresp;
      for (int k = 0; k < r_dly; k++) begin
         chk("r_hold", {31'd0, rvalid}, 32'd1);
         chk("r_data_stable", rdata, d0);
         chk("r_resp_stable", {29'd0, rresp}, {29'd0, r0});
         chk("ar_rdy_low", {31'd0, arready}, 32'd0);
         @(negedge clk);
      end
      rready = 1'b1;
      data   = rdata;
      resp   = rresp;
      @(negedge clk);
      rready = 1'b0;
      chk("r_drop", {31'd0, rvalid}, 32'd0);
      chk("ar_rdy_back", {31'd0, arready}, 32'd1);
   endtask

   task automatic wr_check(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic [4:0] strb, input int aw_dly, input int w_dly, input int b_dly);
      logic [2:0] exp_resp, got_resp;
      exp_resp = model_write(addr, data, strb);
      axi_write(addr, data, strb, aw_dly, w_dly, b_dly, got_resp);
      chk(tag, {29'd0, got_resp}, {29'd0, exp_resp});
   endtask

   task automatic rd_check(input string tag, input logic [7:0] addr, input int ar_dly, input int r_dly);
      logic [31:0] exp_d, got_d;
      logic [2:0]  exp_r, got_r;
      model_read(addr, exp_d, exp_r);
      axi_read(addr, ar_dly, r_dly, got_d, got_r);
      chk({tag, "_data"}, got_d, exp_d);
      chk({tag, "_resp"}, {29'd0, got_r}, {29'd0, exp_r});
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 8; i++) rd_check(tag, 8'(4 * i), 0, 0);
   endtask

   initial begin
      logic [31:0] exp_d, got_d;
      logic [2:0]  exp_r, got_r, wr_r;

      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_awready", {31'd0, awready}, 32'd0);
      chk("rst_wready", {31'd0, wready}, 32'd0);
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_bresp", {29'd0, bresp}, 32'd0);
      chk("rst_rresp", {29'd0, rresp}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      areset = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", {31'd0, awready}, 32'd1);
      chk("post_rst_arready", {31'd0, arready}, 32'd1);
      sweep("init_sweep");

      wr_check("wr00_resp", 8'h00, 32'h0000002A, 5'h0F, 0, 0, 0);
      rd_check("rd00", 8'h00, 0, 0);

      wr_check("wr04a_resp", 8'h04, 32'hAABBCCDD, 5'h0F, 0, 0, 0);
      wr_check("wr04b_resp", 8'h04, 32'h11223344, 5'h05, 0, 0, 0);
      model_read(8'h04, exp_d, exp_r);
      chk("model04", exp_d, 32'hAA22CC44);
      rd_check("rd04", 8'h04, 0, 0);

      wr_check("w_first_resp", 8'h1C, 32'h00000037, 5'h0F, 3, 0, 0);
      rd_check("rd1c", 8'h1C, 0, 0);
      wr_check("aw_first_resp", 8'h18, 32'h12345678, 5'h0F, 0, 2, 0);
      rd_check("rd18", 8'h18, 0, 0);

      wr_check("oor_wr_resp", 8'h20, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
      rd_check("oor_rd40", 8'h40, 0, 0);
      sweep("oor_sweep");

      // Concurrent write and read with five cycles of backpressure on both.
      wr_r = model_write(8'h0C, 32'hCAFEF00D, 5'h0F);
      model_read(8'h10, exp_d, exp_r);
      fork
         axi_write(8'h0C, 32'hCAFEF00D, 5'h0F, 0, 0, 5, got_r);
         axi_read(8'h10, 0, 5, got_d, exp_r);
      join
      chk("bp_bresp", {29'd0, got_r}, {29'd0, wr_r});
      chk("bp_rdata", got_d, exp_d);

      // AR on the commit edge sees the old value; one cycle later, the new one.
      model_read(8'h14, exp_d, exp_r);
      wr_r = model_write(8'h14, 32'h0BADCAFE, 5'h0F);
      fork
         axi_write(8'h14, 32'h0BADCAFE, 5'h0F, 0, 0, 0, got_r);
         axi_read(8'h14, 0, 0, got_d, exp_r);
      join
      chk("same_edge_old", got_d, exp_d);
      model_read(8'h14, exp_d, exp_r);
      wr_r = model_write(8'h14, 32'h00C0FFEE, 5'h03);
      model_read(8'h14, exp_d, exp_r);
      fork
         axi_write(8'h14, 32'h00C0FFEE, 5'h03, 0, 0, 0, got_r);
         axi_read(8'h14, 1, 0, got_d, exp_r);
      join
      chk("next_cycle_new", got_d, exp_d);

      // Reset while a write response is pending.
      @(negedge clk);
      awaddr = 8'h08; wdata = 32'h55; wstrb = 5'h0F;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
      areset = 1'b1;
      @(negedge clk);
      chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("mid_rst_awready", {31'd0, awready}, 32'd0);
      areset = 1'b0;
      model_clear();
      @(negedge clk);
      rd_check("rd08_after_rst", 8'h08, 0, 0);
      sweep("rst_sweep");

      // Random traffic; indices 8..11 exercise the out-of-range path.
      for (int n = 0; n < 80; n++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 47));
         if ($urandom_range(0, 1) == 1) begin
            wr_check("rnd_wr", a, $urandom, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
         end else begin
            rd_check("rnd_rd", a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         end
      end
      sweep("final_sweep");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
